a_lkp_responder: RTL

- Lookup-engine model-in-RTL for the "A" side of the C-to-A lookup interface: accepts c2a lookup requests, searches a small programmable CAM, and returns a2c responses tagged with the request ID.
- Lets top_c_module be simulated and emulated against a synthesizable responder instead of a behavioural driver.
- Responses are in order, fixed pipeline latency; the response channel has no backpressure.

---
 rtl/c_module_pkg.sv | 17 +
 rtl/a_lkp_responder_if.sv | 22 ++
 rtl/a_lkp_req_fifo.sv | 49 ++++
 rtl/a_lkp_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/c_module_pkg.sv
// Shared widths and types for the C-to-A lookup interface.
package c_module_pkg;
  localparam int LKP_INFO_W = 32;
  localparam int REQ_ID_W   = 8;
  localparam int RSLT_W     = 16;
  localparam int ENTRIES    = 16;

  typedef struct packed {
    logic              hit;
    logic [RSLT_W-2:0] data;
  } lkp_rsp_t;

  typedef struct packed {
    logic [REQ_ID_W-1:0]   id;
    logic [LKP_INFO_W-1:0] key;
  } lkp_req_t;
endpackage

// File: rtl/a_lkp_responder_if.sv
// C-to-A lookup channel: request handshake plus unthrottled response.
interface a_lkp_responder_if;
  import c_module_pkg::*;

  logic                  c2a_lkp_vld;
  logic [LKP_INFO_W-1:0] c2a_lkp_info;
  logic [REQ_ID_W-1:0]   c2a_lkp_req_id;
  logic                  a2c_lkp_rdy;
  logic                  a2c_lkp_rsp_vld;
  logic [REQ_ID_W-1:0]   a2c_lkp_rsp_id;
  logic [RSLT_W-1:0]     a2c_lkp_rslt;

  modport master (
    output c2a_lkp_vld, c2a_lkp_info, c2a_lkp_req_id,
    input  a2c_lkp_rdy, a2c_lkp_rsp_vld, a2c_lkp_rsp_id, a2c_lkp_rslt
  );

  modport slave (
    input  c2a_lkp_vld, c2a_lkp_info, c2a_lkp_req_id,
    output a2c_lkp_rdy, a2c_lkp_rsp_vld, a2c_lkp_rsp_id, a2c_lkp_rslt
  );
endinterface

// File: rtl/a_lkp_req_fifo.sv
// Request FIFO: pops every cycle it holds data into a registered head; ready is
// registered from the next-cycle occupancy so it already reflects push and pop.
module a_lkp_req_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  output logic                     rdy,
  output logic                     pop_vld,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q, cnt_nxt;
  logic          do_push, do_pop;

  assign do_push = push && rdy;
  assign do_pop  = (cnt_q != '0);
  assign cnt_nxt = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      rdy     <= 1'b0;
      pop_vld <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q   <= cnt_nxt;
      rdy     <= (cnt_nxt != (AW+1)'(DEPTH));
      pop_vld <= do_pop;
    end
  end

  // Storage and head data need no reset; pop_vld qualifies the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_pop)  pop_data    <= mem[rd_ptr];
  end
endmodule

// File: rtl/a_lkp_responder.sv
// A-side lookup responder: queued requests search a programmable CAM and
// return in-order {hit, data} responses after a fixed pipeline latency.
module a_lkp_responder
  import c_module_pkg::*;
#(
  parameter int ENTRIES    = c_module_pkg::ENTRIES,
  parameter int FIFO_DEPTH = 8,
  parameter int LAT        = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  a_lkp_responder_if.slave              lkp,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(ENTRIES)-1:0]    cfg_wr_idx,
  input  logic                          cfg_wr_vld,
  input  logic [LKP_INFO_W-1:0]         cfg_wr_key,
  input  logic [RSLT_W-2:0]             cfg_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic                vld;
    logic [REQ_ID_W-1:0] id;
    logic                hit;
    logic [IW-1:0]       idx;
  } stg_t;

  logic [ENTRIES-1:0]    cam_vld;
  logic [LKP_INFO_W-1:0] cam_key  [ENTRIES];
  logic [RSLT_W-2:0]     cam_data [ENTRIES];

  logic                  head_vld;
  lkp_req_t              head;
  logic                  s0_hit;
  logic [IW-1:0]         s0_idx;
  stg_t                  stg [LAT];
  lkp_rsp_t              rsp_nxt, rsp_q;
  logic                  rsp_vld_q;
  logic [REQ_ID_W-1:0]   rsp_id_q;

  a_lkp_req_fifo #(.W($bits(lkp_req_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lkp.c2a_lkp_vld),
    .push_data ({lkp.c2a_lkp_req_id, lkp.c2a_lkp_info}),
    .rdy       (lkp.a2c_lkp_rdy),
    .pop_vld   (head_vld),
    .pop_data  (head),
    .cnt       (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cam_vld <= '0;
    else if (cfg_wr_en) cam_vld[cfg_wr_idx] <= cfg_wr_vld;
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      cam_key[cfg_wr_idx]  <= cfg_wr_key;
      cam_data[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Scanning from the top lets the lowest matching index win.
  always_comb begin
    s0_hit = 1'b0;
    s0_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (cam_vld[i] && (cam_key[i] == head.key)) begin
        s0_hit = 1'b1;
        s0_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else begin
      stg[0] <= '{vld: head_vld, id: head.id, hit: s0_hit, idx: s0_idx};
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  always_comb begin
    rsp_nxt = '0;
    if (stg[LAT-1].hit) rsp_nxt = '{hit: 1'b1, data: cam_data[stg[LAT-1].idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_q     <= '0;
    end else begin
      rsp_vld_q <= stg[LAT-1].vld;
      if (stg[LAT-1].vld) begin
        rsp_id_q <= stg[LAT-1].id;
        rsp_q    <= rsp_nxt;
      end
    end
  end

  assign lkp.a2c_lkp_rsp_vld = rsp_vld_q;
  assign lkp.a2c_lkp_rsp_id  = rsp_id_q;
  assign lkp.a2c_lkp_rslt    = rsp_q;
endmodule
